cv32e40p_irq_collector: RTL and testbench

CV32E40P_IRQ_COLLECTOR -- requirements
Module: cv32e40p_irq_collector

---
 rtl/cv32e40p_irq_collector.sv | 124 ++++++++++++
 tb/tb_cv32e40p_irq_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_irq_collector.sv
// rtl/cv32e40p_irq_collector.sv - external interrupt collector feeding the core's irq_i
//
// Synchronises 32 asynchronous interrupt lines and latches them in a PENDING register.
// Each line is either level-sensitive (PENDING follows the synchronised line) or
// rising-edge (PENDING is sticky until acked by the core or cleared by software).
//
// Ports:
//   clk_i         clock, all flops rising-edge
//   rst_i         asynchronous active-high reset
//   irq_src_i     [31:0] asynchronous interrupt source lines
//   irq_o         [31:0] PENDING & ENABLE, driven from flops only
//   irq_ack_i     acknowledge pulse from the core
//   irq_id_i      [4:0] id of the acknowledged interrupt
//   cfg_we_i      register write strobe
//   cfg_addr_i    [1:0] 0=ENABLE 1=EDGE 2=PENDING (W1C) 3=SET (write-only, reads 0)
//   cfg_wdata_i   [31:0] register write data
//   cfg_rdata_o   [31:0] combinational read data
//   missed_cnt_o  [7:0] saturating count of cycles in which an edge was lost

module cv32e40p_irq_collector #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] irq_src_i,
    output logic [31:0] irq_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic [7:0]  missed_cnt_o
);

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_SET     = 2'd3;

    logic [SYNC_STAGES-1:0][31:0] sync_q;
    logic [31:0] prev_q;
    logic [31:0] enable_q;
    logic [31:0] edge_q;
    logic [31:0] pend_q;
    logic [7:0]  missed_q;

    logic        wr_enable;
    logic        wr_edge;
    logic        wr_pend;
    logic        wr_set;
    logic [31:0] sync_val;
    logic [31:0] rise;
    logic [31:0] ack_vec;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] edge_pend_nxt;
    logic [31:0] edge_on;
    logic [31:0] pend_nxt;
    logic        miss_hit;

    always_comb begin
        wr_enable     = cfg_we_i && (cfg_addr_i == ADDR_ENABLE);
        wr_edge       = cfg_we_i && (cfg_addr_i == ADDR_EDGE);
        wr_pend       = cfg_we_i && (cfg_addr_i == ADDR_PENDING);
        wr_set        = cfg_we_i && (cfg_addr_i == ADDR_SET);
        sync_val      = sync_q[SYNC_STAGES-1];
        rise          = sync_val & ~prev_q;
        ack_vec       = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;
        set_vec       = rise | (wr_set ? cfg_wdata_i : 32'd0);
        clr_vec       = ack_vec | (wr_pend ? cfg_wdata_i : 32'd0);
        // Set dominates clear so a fresh edge coinciding with an ack is never lost.
        edge_pend_nxt = set_vec | (pend_q & ~clr_vec);
        // A line switching from level to edge mode starts with a clean PENDING bit.
        edge_on       = wr_edge ? (cfg_wdata_i & ~edge_q) : 32'd0;
        pend_nxt      = ((edge_q & edge_pend_nxt) | (~edge_q & sync_val)) & ~edge_on;
        // Any number of lost edges in one cycle counts as a single miss.
        miss_hit      = |(rise & edge_q & pend_q & ~clr_vec);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            prev_q   <= '0;
            enable_q <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
            missed_q <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src_i};
            end else begin
                sync_q <= irq_src_i;
            end
            prev_q <= sync_val;
            pend_q <= pend_nxt;
            if (wr_enable) begin
                enable_q <= cfg_wdata_i;
            end
            if (wr_edge) begin
                edge_q <= cfg_wdata_i;
            end
            if (wr_pend && (cfg_wdata_i == 32'd0)) begin
                missed_q <= '0;
            end else if (miss_hit && (missed_q != 8'hFF)) begin
                missed_q <= missed_q + 8'd1;
            end
        end
    end

    assign irq_o        = pend_q & enable_q;
    assign missed_cnt_o = missed_q;

    always_comb begin
        cfg_rdata_o = 32'd0;
        case (cfg_addr_i)
            ADDR_ENABLE:  cfg_rdata_o = enable_q;
            ADDR_EDGE:    cfg_rdata_o = edge_q;
            ADDR_PENDING: cfg_rdata_o = pend_q;
            default:      cfg_rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cv32e40p_irq_collector.sv
// tb/tb_cv32e40p_irq_collector.sv - self-checking bench for cv32e40p_irq_collector

module tb_cv32e40p_irq_collector;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] irq_src = '0;
    logic [31:0] irq_out;
    logic        irq_ack = 1'b0;
    logic [4:0]  irq_id = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic [7:0]  missed;

    int total = 0;
    int bad = 0;

    // Reference model: a delay line of sampled source values plus the register state.
    logic [31:0] hist [0:S+1];
    logic [31:0] m_en, m_edge, m_pend;
    int          m_miss;

    cv32e40p_irq_collector #(.SYNC_STAGES(S)) dut (
        .clk_i(clk), .rst_i(rst), .irq_src_i(irq_src), .irq_o(irq_out),
        .irq_ack_i(irq_ack), .irq_id_i(irq_id), .cfg_we_i(cfg_we),
        .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
        .missed_cnt_o(missed)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return m_en;
            2'd1: return m_edge;
            2'd2: return m_pend;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k <= S + 1; k++) hist[k] = '0;
        m_en = '0; m_edge = '0; m_pend = '0; m_miss = 0;
    endtask

    // Advance one clock: compute the model's next state from the applied inputs,
    // then let the DUT take the edge and commit.
    task automatic step();
        logic [31:0] h [0:S+1];
        logic [31:0] n_pend, n_en, n_edge;
        logic sy, pv, rs, hit_set, hit_clr;
        bit any_miss;
        int n_miss;
        h[0] = irq_src;
        for (int k = 1; k <= S + 1; k++) h[k] = hist[k-1];
        any_miss = 0;
        for (int i = 0; i < 32; i++) begin
            sy = h[S][i];
            pv = h[S+1][i];
            rs = sy && !pv;
            hit_clr = (irq_ack && irq_id == i) || (cfg_we && cfg_addr == 2 && cfg_wdata[i]);
            hit_set = rs || (cfg_we && cfg_addr == 3 && cfg_wdata[i]);
            if (!m_edge[i]) n_pend[i] = sy;
            else if (hit_set) n_pend[i] = 1'b1;
            else if (hit_clr) n_pend[i] = 1'b0;
            else n_pend[i] = m_pend[i];
            if (cfg_we && cfg_addr == 1 && cfg_wdata[i] && !m_edge[i]) n_pend[i] = 1'b0;
            if (m_edge[i] && rs && m_pend[i] && !hit_clr) any_miss = 1;
        end
        n_miss = m_miss;
        if (cfg_we && cfg_addr == 2 && cfg_wdata == 0) n_miss = 0;
        else if (any_miss && m_miss < 255) n_miss = m_miss + 1;
        n_en = (cfg_we && cfg_addr == 0) ? cfg_wdata : m_en;
        n_edge = (cfg_we && cfg_addr == 1) ? cfg_wdata : m_edge;
        @(posedge clk);
        #1;
        for (int k = 0; k <= S + 1; k++) hist[k] = h[k];
        m_pend = n_pend; m_en = n_en; m_edge = n_edge; m_miss = n_miss;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq_src = '0; irq_ack = 0; cfg_we = 0; cfg_wdata = '0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (irq_out !== 32'd0) begin bad++; $display("FAIL reset_irq got=%h exp=0", irq_out); end
        total++;
        if (missed !== 8'd0) begin bad++; $display("FAIL reset_missed got=%0d exp=0", missed); end
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a); #1;
            total++;
            if (cfg_rdata !== 32'd0) begin bad++; $display("FAIL reset_read%0d got=%h exp=0", a, cfg_rdata); end
        end
    endtask

    task automatic test_level();
        do_reset();
        cfg_write(0, 32'h80);
        irq_src[7] = 1'b1;
        steps(2);
        total++;
        if (irq_out !== 32'd0) begin bad++; $display("FAIL level_early got=%h exp=0", irq_out); end
        step();
        total++;
        if (irq_out !== 32'h80) begin bad++; $display("FAIL level_rise got=%h exp=80", irq_out); end
        irq_src[7] = 1'b0;
        steps(2);
        total++;
        if (irq_out !== 32'h80) begin bad++; $display("FAIL level_hold got=%h exp=80", irq_out); end
        step();
        total++;
        if (irq_out !== 32'd0) begin bad++; $display("FAIL level_fall got=%h exp=0", irq_out); end
    endtask

    task automatic test_edge();
        do_reset();
        cfg_write(0, 32'h08);
        cfg_write(1, 32'h08);
        irq_src[3] = 1'b1;
        steps(2);
        irq_src[3] = 1'b0;
        steps(6);
        total++;
        if (irq_out !== 32'h08) begin bad++; $display("FAIL edge_sticky got=%h exp=08", irq_out); end
        irq_ack = 1'b1; irq_id = 5'd3;
        step();
        irq_ack = 1'b0;
        total++;
        if (irq_out !== 32'd0) begin bad++; $display("FAIL edge_ack got=%h exp=0", irq_out); end
    endtask

    task automatic test_collision();
        // Continues from test_edge: line 3 edge mode, enabled, not pending, source low.
        irq_src[3] = 1'b1;
        steps(3);
        irq_src[3] = 1'b0;
        steps(3);
        total++;
        if (irq_out[3] !== 1'b1) begin bad++; $display("FAIL coll_setup got=%b exp=1", irq_out[3]); end
        irq_src[3] = 1'b1;
        steps(2);
        irq_ack = 1'b1; irq_id = 5'd3;
        step();
        irq_ack = 1'b0;
        total++;
        if (irq_out[3] !== 1'b1) begin bad++; $display("FAIL coll_pend got=%b exp=1", irq_out[3]); end
        total++;
        if (missed !== 8'd0) begin bad++; $display("FAIL coll_missed got=%0d exp=0", missed); end
    endtask

    task automatic test_missed();
        do_reset();
        cfg_write(1, 32'h20);
        cfg_write(3, 32'h20);
        for (int n = 0; n < 300; n++) begin
            irq_src[5] = 1'b1; step();
            irq_src[5] = 1'b0; step();
        end
        steps(4);
        total++;
        if (missed !== 8'd255) begin bad++; $display("FAIL missed_sat got=%0d exp=255", missed); end
        cfg_write(2, 32'd0);
        total++;
        if (missed !== 8'd0) begin bad++; $display("FAIL missed_clr got=%0d exp=0", missed); end
    endtask

    task automatic test_set_w1c();
        do_reset();
        cfg_write(1, 32'h11);
        cfg_write(0, 32'h01);
        cfg_write(3, 32'h11);
        total++;
        if (irq_out !== 32'h01) begin bad++; $display("FAIL set_irq got=%h exp=01", irq_out); end
        cfg_addr = 2; #1;
        total++;
        if (cfg_rdata !== 32'h11) begin bad++; $display("FAIL set_pend got=%h exp=11", cfg_rdata); end
        cfg_addr = 3; #1;
        total++;
        if (cfg_rdata !== 32'd0) begin bad++; $display("FAIL set_read got=%h exp=0", cfg_rdata); end
        cfg_write(2, 32'h10);
        cfg_addr = 2; #1;
        total++;
        if (cfg_rdata !== 32'h01) begin bad++; $display("FAIL w1c_pend got=%h exp=01", cfg_rdata); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_write(0, 32'hFF);
        irq_src = 32'hFF;
        steps(3);
        total++;
        if (irq_out !== 32'hFF) begin bad++; $display("FAIL arst_setup got=%h exp=ff", irq_out); end
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        total++;
        if (irq_out !== 32'd0) begin bad++; $display("FAIL arst_irq got=%h exp=0", irq_out); end
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a); #1;
            total++;
            if (cfg_rdata !== 32'd0) begin bad++; $display("FAIL arst_read%0d got=%h exp=0", a, cfg_rdata); end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Source still high: level lines re-pend after the synchroniser latency.
        steps(3);
        cfg_addr = 2; #1;
        total++;
        if (cfg_rdata !== 32'hFF) begin bad++; $display("FAIL arst_repend got=%h exp=ff", cfg_rdata); end
        irq_src = '0;
    endtask

    task automatic test_random();
        logic [1:0] ra;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ ($urandom & $urandom & $urandom);
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_wdata = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            irq_ack = ($urandom_range(0, 2) == 0);
            irq_id = 5'($urandom_range(0, 31));
            step();
            cfg_we = 1'b0;
            irq_ack = 1'b0;
            total++;
            if (irq_out !== (m_pend & m_en)) begin
                bad++; $display("FAIL rand_irq cyc=%0d got=%h exp=%h", n, irq_out, m_pend & m_en);
            end
            total++;
            if (missed !== 8'(m_miss)) begin
                bad++; $display("FAIL rand_missed cyc=%0d got=%0d exp=%0d", n, missed, m_miss);
            end
            ra = 2'($urandom_range(0, 3));
            cfg_addr = ra; #1;
            total++;
            if (cfg_rdata !== model_read(ra)) begin
                bad++; $display("FAIL rand_read cyc=%0d addr=%0d got=%h exp=%h", n, ra, cfg_rdata, model_read(ra));
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_level();
        test_edge();
        test_collision();
        test_missed();
        test_set_w1c();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
